// File: rtl/cam_fifo_capture.sv
`default_nettype none
// ============================================================================
//  Module   : cam_fifo_capture
//  Purpose  : Captures one camera frame into an AL422B-class FIFO, then reads it
//             back and packs bytes into pixels on a valid/ready stream.
//  Revision : 1.0
// ============================================================================
module cam_fifo_capture #(
   parameter int CLK_DIV   = 4,
   parameter int PIX_BYTES = 2,
   parameter int FRAME_PIX = 76800,
   parameter int CNT_W     = 17,
   parameter int RST_CYC   = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   input  logic                   vsync,
   input  logic [7:0]             fifo_din,
   output logic                   fifo_wen_n,
   output logic                   fifo_wrst_n,
   output logic                   fifo_rrst_n,
   output logic                   fifo_oe_n,
   output logic                   fifo_rclk,
   output logic [8*PIX_BYTES-1:0] pix_data,
   output logic                   pix_valid,
   input  logic                   pix_ready,
   output logic                   pix_last,
   output logic                   busy,
   output logic                   done
);

   localparam int PW     = 8 * PIX_BYTES;
   localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BYTE_W = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
   localparam int RST_W  = $clog2(RST_CYC);

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(PIX_BYTES - 1);
   localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYC - 1);
   localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(FRAME_PIX - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WRST      = 3'd1,
      WAIT_RISE = 3'd2,
      WAIT_FALL = 3'd3,
      CAPTURE   = 3'd4,
      RRST      = 3'd5,
      READ      = 3'd6,
      DONE      = 3'd7
   } state_t;

   state_t state;
   state_t state_nxt;

   logic vs_meta;
   logic vs_sync;
   logic vs_prev;
   logic vs_rise;
   logic vs_fall;

   logic [RST_W-1:0]  rst_cnt;
   logic              rst_done;
   logic [DIV_W-1:0]  div_cnt;
   logic              div_tick;
   logic [BYTE_W-1:0] byte_cnt;
   logic              last_byte;
   logic [CNT_W-1:0]  pix_cnt;
   logic [CNT_W-1:0]  load_idx;
   logic              read_end;
   logic [PW-1:0]     shreg;
   logic [PW-1:0]     shreg_nxt;
   logic              full;
   logic              hold;
   logic              sample;
   logic              load;
   logic              xfer;

   // vsync is asynchronous: two flops, then edge detection on the clean copy
   always_ff @(posedge clk) begin
      if (reset) begin
         vs_meta <= 1'b0;
         vs_sync <= 1'b0;
         vs_prev <= 1'b0;
      end else begin
         vs_meta <= vsync;
         vs_sync <= vs_meta;
         vs_prev <= vs_sync;
      end
   end

   assign vs_rise = vs_sync & ~vs_prev;
   assign vs_fall = ~vs_sync & vs_prev;

   assign rst_done  = (rst_cnt == RST_LAST);
   assign div_tick  = (div_cnt == DIV_LAST);
   assign last_byte = (byte_cnt == BYTE_LAST);
   assign xfer      = pix_valid & pix_ready;
   assign full      = pix_valid & ~pix_ready;
   // Index of the pixel about to be loaded; a pending pixel occupies pix_cnt
   assign load_idx  = pix_cnt + CNT_W'(pix_valid);
   assign shreg_nxt = (shreg << 8) | PW'(fifo_din);

   // The single-pixel packer cannot accept a completing byte while occupied:
   // park rclk low before the last byte's rising edge, or stop the falling
   // edge if the consumer withdrew ready during the high phase.
   assign hold   = read_end | (last_byte & full & (~fifo_rclk | div_tick));
   assign sample = (state == READ) & fifo_rclk & div_tick & ~hold;
   assign load   = sample & last_byte;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (start)          state_nxt = WRST;
         WRST:      if (rst_done)       state_nxt = WAIT_RISE;
         WAIT_RISE: if (vs_rise)        state_nxt = WAIT_FALL;
         WAIT_FALL: if (vs_fall)        state_nxt = CAPTURE;
         CAPTURE:   if (vs_rise)        state_nxt = RRST;
         RRST:      if (rst_done)       state_nxt = READ;
         READ:      if (xfer && pix_last) state_nxt = DONE;
         DONE:                          state_nxt = IDLE;
         default:                       state_nxt = IDLE;
      endcase
      if (abort) begin
         state_nxt = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rst_cnt   <= '0;
         div_cnt   <= '0;
         fifo_rclk <= 1'b0;
         byte_cnt  <= '0;
         pix_cnt   <= '0;
         read_end  <= 1'b0;
         shreg     <= '0;
         pix_data  <= '0;
         pix_valid <= 1'b0;
         pix_last  <= 1'b0;
      end else if (abort) begin
         rst_cnt   <= '0;
         div_cnt   <= '0;
         fifo_rclk <= 1'b0;
         byte_cnt  <= '0;
         pix_cnt   <= '0;
         read_end  <= 1'b0;
         shreg     <= '0;
         pix_valid <= 1'b0;
         pix_last  <= 1'b0;
      end else begin
         if ((state == WRST || state == RRST) && !rst_done) begin
            rst_cnt <= rst_cnt + RST_W'(1);
         end else begin
            rst_cnt <= '0;
         end

         case (state)
            RRST: begin
               // The FIFO needs read clocks while its read pointer resets
               if (rst_done) begin
                  div_cnt   <= '0;
                  fifo_rclk <= 1'b0;
                  byte_cnt  <= '0;
                  pix_cnt   <= '0;
                  read_end  <= 1'b0;
                  pix_valid <= 1'b0;
                  pix_last  <= 1'b0;
               end else if (div_tick) begin
                  div_cnt   <= '0;
                  fifo_rclk <= ~fifo_rclk;
               end else begin
                  div_cnt <= div_cnt + DIV_W'(1);
               end
            end

            READ: begin
               if (!hold) begin
                  if (div_tick) begin
                     div_cnt   <= '0;
                     fifo_rclk <= ~fifo_rclk;
                  end else begin
                     div_cnt <= div_cnt + DIV_W'(1);
                  end
               end

               if (sample) begin
                  if (last_byte) begin
                     byte_cnt <= '0;
                     pix_data <= shreg_nxt;
                     pix_last <= (load_idx == LAST_IDX);
                     if (load_idx == LAST_IDX) begin
                        read_end <= 1'b1;
                     end
                  end else begin
                     byte_cnt <= byte_cnt + BYTE_W'(1);
                     shreg    <= shreg_nxt;
                  end
               end

               if (xfer && pix_cnt != CNT_MAX) begin
                  pix_cnt <= pix_cnt + CNT_W'(1);
               end

               if (load) begin
                  pix_valid <= 1'b1;
               end else if (xfer) begin
                  pix_valid <= 1'b0;
                  pix_last  <= 1'b0;
               end
            end

            default: begin
               div_cnt   <= '0;
               fifo_rclk <= 1'b0;
               pix_valid <= 1'b0;
               pix_last  <= 1'b0;
            end
         endcase
      end
   end

   assign fifo_wrst_n = (state != WRST);
   assign fifo_wen_n  = (state != CAPTURE);
   assign fifo_rrst_n = (state != RRST);
   assign fifo_oe_n   = !(state == RRST || state == READ);
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_cam_fifo_capture.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cam_fifo_capture
//  Purpose  : Self-checking bench for cam_fifo_capture with a behavioural FIFO.
//  Revision : 1.0
// ============================================================================
module tb_cam_fifo_capture;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic        vsync;
   logic [7:0]  fifo_din;
   logic        fifo_wen_n;
   logic        fifo_wrst_n;
   logic        fifo_rrst_n;
   logic        fifo_oe_n;
   logic        fifo_rclk;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        pix_ready;
   logic        pix_last;
   logic        busy;
   logic        done;

   int checks   = 0;
   int failures = 0;

   logic [16:0] got[$];
   logic [16:0] exp_q[$];
   int wrst_low   = 0;
   int rrst_low   = 0;
   int wen_low    = 0;
   int done_cnt   = 0;
   int rclk_edges = 0;
   int hold_err   = 0;
   logic        rclk_prev  = 1'b0;
   logic        stall_prev = 1'b0;
   logic [15:0] data_prev  = '0;
   logic        last_prev  = 1'b0;
   int rd_ptr = 0;

   always #5 clk = ~clk;

   cam_fifo_capture #(
      .CLK_DIV   (1),
      .PIX_BYTES (2),
      .FRAME_PIX (4),
      .CNT_W     (3),
      .RST_CYC   (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .abort       (abort),
      .vsync       (vsync),
      .fifo_din    (fifo_din),
      .fifo_wen_n  (fifo_wen_n),
      .fifo_wrst_n (fifo_wrst_n),
      .fifo_rrst_n (fifo_rrst_n),
      .fifo_oe_n   (fifo_oe_n),
      .fifo_rclk   (fifo_rclk),
      .pix_data    (pix_data),
      .pix_valid   (pix_valid),
      .pix_ready   (pix_ready),
      .pix_last    (pix_last),
      .busy        (busy),
      .done        (done)
   );

   // FIFO read port: data for address rd_ptr appears after each rclk rise
   initial fifo_din = 8'h00;
   always @(posedge fifo_rclk) begin
      if (!fifo_rrst_n) begin
         rd_ptr = 0;
      end else begin
         fifo_din = (rd_ptr < 8) ? 8'(rd_ptr + 1) : 8'hEE;
         rd_ptr = rd_ptr + 1;
      end
   end

   always @(negedge clk) begin
      if (pix_valid && pix_ready) got.push_back({pix_last, pix_data});
      if (!fifo_wrst_n) wrst_low++;
      if (!fifo_rrst_n) rrst_low++;
      if (!fifo_wen_n) wen_low++;
      if (done) done_cnt++;
      if (fifo_rclk != rclk_prev) rclk_edges++;
      rclk_prev = fifo_rclk;
      if (stall_prev && (!pix_valid || pix_data !== data_prev || pix_last !== last_prev))
         hold_err++;
      stall_prev = pix_valid && !pix_ready;
      data_prev  = pix_data;
      last_prev  = pix_last;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic pulse_start;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic vsync_pulse(input int low_len);
      @(posedge clk); #1 vsync = 1'b1;
      repeat (3) @(posedge clk);
      #1 vsync = 1'b0;
      repeat (low_len) @(posedge clk);
      #1 vsync = 1'b1;
      repeat (3) @(posedge clk);
      #1 vsync = 1'b0;
   endtask

   task automatic wait_pix(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         if (got.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic push_frame;
      for (int k = 0; k < 4; k++)
         exp_q.push_back({(k == 3), 8'(2 * k + 1), 8'(2 * k + 2)});
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; abort = 1'b0; vsync = 1'b0; pix_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (fifo_wen_n !== 1'b1)  begin failures++; $display("FAIL reset_wen_n got=%b exp=1", fifo_wen_n); end
      checks++; if (fifo_wrst_n !== 1'b1) begin failures++; $display("FAIL reset_wrst_n got=%b exp=1", fifo_wrst_n); end
      checks++; if (fifo_rrst_n !== 1'b1) begin failures++; $display("FAIL reset_rrst_n got=%b exp=1", fifo_rrst_n); end
      checks++; if (fifo_oe_n !== 1'b1)   begin failures++; $display("FAIL reset_oe_n got=%b exp=1", fifo_oe_n); end
      checks++; if (fifo_rclk !== 1'b0)   begin failures++; $display("FAIL reset_rclk got=%b exp=0", fifo_rclk); end
      checks++; if (pix_valid !== 1'b0)   begin failures++; $display("FAIL reset_pix_valid got=%b exp=0", pix_valid); end
      checks++; if (pix_last !== 1'b0)    begin failures++; $display("FAIL reset_pix_last got=%b exp=0", pix_last); end
      checks++; if (pix_data !== 16'h0)   begin failures++; $display("FAIL reset_pix_data got=%h exp=0000", pix_data); end
      checks++; if (busy !== 1'b0)        begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (done !== 1'b0)        begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
      @(posedge clk); #1 reset = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_frame;
      int base, w0, r0, e0, d0;
      bit ok;
      logic [16:0] e;
      base = got.size(); w0 = wrst_low; r0 = rrst_low; e0 = wen_low; d0 = done_cnt;
      pix_ready = 1'b1;
      push_frame();
      pulse_start();
      repeat (12) @(posedge clk);
      vsync_pulse(6);
      wait_pix(base + 4, 200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL frame_timeout got=%0d exp=4 pixels", got.size() - base); end
      repeat (6) @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (got.size() <= base + k) begin
            failures++; $display("FAIL frame_pix%0d got=none exp=%h", k, e);
         end else if (got[base + k] !== e) begin
            failures++; $display("FAIL frame_pix%0d got=%h exp=%h", k, got[base + k], e);
         end
      end
      checks++; if (got.size() - base != 4) begin failures++; $display("FAIL frame_count got=%0d exp=4", got.size() - base); end
      checks++; if (wrst_low - w0 != 8) begin failures++; $display("FAIL frame_wrst_len got=%0d exp=8", wrst_low - w0); end
      checks++; if (rrst_low - r0 != 8) begin failures++; $display("FAIL frame_rrst_len got=%0d exp=8", rrst_low - r0); end
      checks++; if (wen_low - e0 != 6) begin failures++; $display("FAIL frame_wen_len got=%0d exp=6", wen_low - e0); end
      checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL frame_done got=%0d exp=1", done_cnt - d0); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL frame_idle got=%b exp=0", busy); end
   endtask

   task automatic test_backpressure;
      int base, d0, ed0, h0;
      bit ok;
      logic [16:0] e;
      base = got.size(); d0 = done_cnt; h0 = hold_err;
      pix_ready = 1'b1;
      push_frame();
      pulse_start();
      repeat (12) @(posedge clk);
      vsync_pulse(6);
      wait_pix(base + 1, 200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL bp_first_timeout got=%0d exp=1", got.size() - base); end
      #1 pix_ready = 1'b0;
      repeat (6) @(posedge clk);
      ed0 = rclk_edges;
      repeat (4) @(posedge clk);
      checks++; if (rclk_edges - ed0 != 0) begin failures++; $display("FAIL bp_rclk_frozen got=%0d edges exp=0", rclk_edges - ed0); end
      @(negedge clk);
      checks++; if (pix_valid !== 1'b1 || pix_data !== 16'h0304) begin
         failures++; $display("FAIL bp_held got=%b/%h exp=1/0304", pix_valid, pix_data);
      end
      @(posedge clk); #1 pix_ready = 1'b1;
      wait_pix(base + 4, 200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL bp_timeout got=%0d exp=4", got.size() - base); end
      repeat (6) @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (got.size() <= base + k) begin
            failures++; $display("FAIL bp_pix%0d got=none exp=%h", k, e);
         end else if (got[base + k] !== e) begin
            failures++; $display("FAIL bp_pix%0d got=%h exp=%h", k, got[base + k], e);
         end
      end
      checks++; if (got.size() - base != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got.size() - base); end
      checks++; if (hold_err - h0 != 0) begin failures++; $display("FAIL bp_stable got=%0d changes exp=0", hold_err - h0); end
      checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL bp_done got=%0d exp=1", done_cnt - d0); end
   endtask

   task automatic test_vsync_high;
      int base, w0, r0, e0, d0;
      bit ok;
      logic [16:0] e;
      base = got.size(); w0 = wrst_low; r0 = rrst_low; d0 = done_cnt;
      pix_ready = 1'b1;
      push_frame();
      @(posedge clk); #1 vsync = 1'b1;
      repeat (5) @(posedge clk);
      pulse_start();
      repeat (30) @(posedge clk);
      @(negedge clk);
      checks++; if (busy !== 1'b1 || fifo_wen_n !== 1'b1) begin
         failures++; $display("FAIL vh_waiting got=busy%b/wen_n%b exp=1/1", busy, fifo_wen_n);
      end
      checks++; if (rrst_low - r0 != 0) begin failures++; $display("FAIL vh_no_read got=%0d exp=0", rrst_low - r0); end
      checks++; if (wrst_low - w0 != 8) begin failures++; $display("FAIL vh_wrst_len got=%0d exp=8", wrst_low - w0); end
      e0 = wen_low;
      @(posedge clk); #1 vsync = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++; if (fifo_wen_n !== 1'b1) begin failures++; $display("FAIL vh_first_low got=%b exp=1", fifo_wen_n); end
      vsync_pulse(5);
      wait_pix(base + 4, 200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL vh_timeout got=%0d exp=4", got.size() - base); end
      repeat (6) @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (got.size() <= base + k) begin
            failures++; $display("FAIL vh_pix%0d got=none exp=%h", k, e);
         end else if (got[base + k] !== e) begin
            failures++; $display("FAIL vh_pix%0d got=%h exp=%h", k, got[base + k], e);
         end
      end
      checks++; if (wen_low - e0 != 5) begin failures++; $display("FAIL vh_wen_len got=%0d exp=5", wen_low - e0); end
      checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL vh_done got=%0d exp=1", done_cnt - d0); end
   endtask

   task automatic test_abort;
      int base, d0;
      bit ok;
      logic [16:0] e;
      base = got.size(); d0 = done_cnt;
      pix_ready = 1'b1;
      exp_q.push_back({1'b0, 16'h0102});
      exp_q.push_back({1'b0, 16'h0304});
      pulse_start();
      repeat (12) @(posedge clk);
      vsync_pulse(6);
      wait_pix(base + 2, 200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL abort_timeout got=%0d exp=2", got.size() - base); end
      #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      @(negedge clk);
      checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL abort_idle got=%b exp=0", busy); end
      checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL abort_valid got=%b exp=0", pix_valid); end
      checks++; if (fifo_rclk !== 1'b0) begin failures++; $display("FAIL abort_rclk got=%b exp=0", fifo_rclk); end
      checks++; if (fifo_oe_n !== 1'b1) begin failures++; $display("FAIL abort_oe_n got=%b exp=1", fifo_oe_n); end
      repeat (10) @(posedge clk);
      checks++; if (done_cnt - d0 != 0) begin failures++; $display("FAIL abort_done got=%0d exp=0", done_cnt - d0); end
      for (int k = 0; k < 2; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (got.size() <= base + k) begin
            failures++; $display("FAIL abort_pix%0d got=none exp=%h", k, e);
         end else if (got[base + k] !== e) begin
            failures++; $display("FAIL abort_pix%0d got=%h exp=%h", k, got[base + k], e);
         end
      end
      test_frame();
   endtask

   task automatic test_start_ignored;
      int base, w0, d0;
      bit ok, in_read;
      logic [16:0] e;
      base = got.size(); w0 = wrst_low; d0 = done_cnt;
      pix_ready = 1'b1;
      push_frame();
      pulse_start();
      repeat (12) @(posedge clk);
      @(posedge clk); #1 vsync = 1'b1;
      repeat (3) @(posedge clk);
      #1 vsync = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++; if (fifo_wen_n !== 1'b0) begin failures++; $display("FAIL si_capture got=%b exp=0", fifo_wen_n); end
      pulse_start();
      repeat (2) @(posedge clk);
      #1 vsync = 1'b1;
      repeat (3) @(posedge clk);
      #1 vsync = 1'b0;
      in_read = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (!fifo_oe_n && fifo_rrst_n) begin
            in_read = 1'b1;
            break;
         end
      end
      checks++; if (!in_read) begin failures++; $display("FAIL si_read_timeout got=0 exp=1"); end
      pulse_start();
      wait_pix(base + 4, 200, ok);
      checks++; if (!ok) begin failures++; $display("FAIL si_timeout got=%0d exp=4", got.size() - base); end
      repeat (40) @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front();
         checks++;
         if (got.size() <= base + k) begin
            failures++; $display("FAIL si_pix%0d got=none exp=%h", k, e);
         end else if (got[base + k] !== e) begin
            failures++; $display("FAIL si_pix%0d got=%h exp=%h", k, got[base + k], e);
         end
      end
      checks++; if (got.size() - base != 4) begin failures++; $display("FAIL si_count got=%0d exp=4", got.size() - base); end
      checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL si_done got=%0d exp=1", done_cnt - d0); end
      checks++; if (wrst_low - w0 != 8) begin failures++; $display("FAIL si_one_frame got=%0d exp=8", wrst_low - w0); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL si_idle got=%b exp=0", busy); end
   endtask

   initial begin
      test_reset();
      test_frame();
      test_backpressure();
      test_vsync_high();
      test_abort();
      test_start_ignored();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
